// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//   Shares the single write port of the 32x64 register file between the
//   pipeline writeback (req0) and the load/debug port (req1). Each requester
//   owns a one-entry holding buffer behind a valid/ready handshake. A
//   round-robin arbiter drains the buffers into a registered write port that
//   also drives the one-hot per-register enable (wr_dec). Writes aimed at the
//   hard-wired zero register are accepted, discarded and counted.
//
// Ports
//   clk                 clock, all state updates on posedge
//   reset               asynchronous, active-low reset
//   req0_valid/ready    writeback handshake; req0_addr/req0_data payload
//   req1_valid/ready    load/debug handshake; req1_addr/req1_data payload
//   wr_en               register-file write strobe (registered)
//   wr_addr/wr_data     register-file write address/data (registered)
//   wr_dec              one-hot enable: bit wr_addr set iff wr_en
//   pending             holding-buffer full flags {hold1, hold0}
//   drop_cnt            saturating count of dropped zero-register writes
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 31,
  parameter int DROP_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [DATA_W-1:0]   req0_data,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [DATA_W-1:0]   req1_data,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic [NUM_REGS-1:0] wr_dec,
  output logic [1:0]          pending,
  output logic [DROP_W-1:0]   drop_cnt
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

  // Holding buffers
  buf_state_t          hold0_q, hold0_d;
  buf_state_t          hold1_q, hold1_d;
  logic [ADDR_W-1:0]   addr0_q, addr0_d;
  logic [ADDR_W-1:0]   addr1_q, addr1_d;
  logic [DATA_W-1:0]   data0_q, data0_d;
  logic [DATA_W-1:0]   data1_q, data1_d;

  // Arbiter and write port
  logic                last_grant_q, last_grant_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [NUM_REGS-1:0] wr_dec_q, wr_dec_d;
  logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;

  // Combinational helpers
  logic                full0_s, full1_s;
  logic                gnt_valid_s, gnt_idx_s;
  logic                gnt0_s, gnt1_s;
  logic                ready0_s, ready1_s;
  logic                hs0_s, hs1_s;
  logic                drop0_s, drop1_s;
  logic                cap0_s, cap1_s;
  logic [ADDR_W-1:0]   gnt_addr_s;
  logic [DATA_W-1:0]   gnt_data_s;
  logic [DROP_W:0]     drop_inc_s;
  logic [DROP_W:0]     drop_sum_s;

  // Arbitration, handshake decode and ready generation
  always_comb begin
    full0_s     = (hold0_q == BUF_FULL);
    full1_s     = (hold1_q == BUF_FULL);
    gnt_valid_s = 1'b0;
    gnt_idx_s   = 1'b0;
    case ({full1_s, full0_s})
      2'b01: begin
        gnt_valid_s = 1'b1;
        gnt_idx_s   = 1'b0;
      end
      2'b10: begin
        gnt_valid_s = 1'b1;
        gnt_idx_s   = 1'b1;
      end
      2'b11: begin
        // Contention: favour whoever did not win last time.
        gnt_valid_s = 1'b1;
        gnt_idx_s   = ~last_grant_q;
      end
      default: begin
        gnt_valid_s = 1'b0;
        gnt_idx_s   = 1'b0;
      end
    endcase
    gnt0_s   = gnt_valid_s & (gnt_idx_s == 1'b0);
    gnt1_s   = gnt_valid_s & (gnt_idx_s == 1'b1);
    // A buffer being drained this edge can accept a refill on the same edge.
    ready0_s = ~full0_s | gnt0_s;
    ready1_s = ~full1_s | gnt1_s;
    hs0_s    = req0_valid & ready0_s;
    hs1_s    = req1_valid & ready1_s;
    drop0_s  = hs0_s & (req0_addr == ZERO_ADDR);
    drop1_s  = hs1_s & (req1_addr == ZERO_ADDR);
    cap0_s   = hs0_s & ~drop0_s;
    cap1_s   = hs1_s & ~drop1_s;
    if (gnt_idx_s) begin
      gnt_addr_s = addr1_q;
      gnt_data_s = data1_q;
    end else begin
      gnt_addr_s = addr0_q;
      gnt_data_s = data0_q;
    end
  end

  // Holding-buffer next state: refill takes priority over drain
  always_comb begin
    hold0_d = hold0_q;
    addr0_d = addr0_q;
    data0_d = data0_q;
    hold1_d = hold1_q;
    addr1_d = addr1_q;
    data1_d = data1_q;
    if (cap0_s) begin
      hold0_d = BUF_FULL;
      addr0_d = req0_addr;
      data0_d = req0_data;
    end else if (gnt0_s) begin
      hold0_d = BUF_EMPTY;
    end else begin
      hold0_d = hold0_q;
    end
    if (cap1_s) begin
      hold1_d = BUF_FULL;
      addr1_d = req1_addr;
      data1_d = req1_data;
    end else if (gnt1_s) begin
      hold1_d = BUF_EMPTY;
    end else begin
      hold1_d = hold1_q;
    end
  end

  // Saturating dropped-write counter; up to two drops per cycle
  always_comb begin
    drop_inc_s = {{DROP_W{1'b0}}, drop0_s} + {{DROP_W{1'b0}}, drop1_s};
    drop_sum_s = {1'b0, drop_cnt_q} + drop_inc_s;
    // The sum never exceeds all-ones plus 2, so the carry bit flags overflow.
    if (drop_sum_s[DROP_W]) begin
      drop_cnt_d = {DROP_W{1'b1}};
    end else begin
      drop_cnt_d = drop_sum_s[DROP_W-1:0];
    end
  end

  // Write-port next state: strobe, payload and one-hot decode
  always_comb begin
    wr_en_d      = gnt_valid_s;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_dec_d     = {NUM_REGS{1'b0}};
    last_grant_d = last_grant_q;
    if (gnt_valid_s) begin
      wr_addr_d    = gnt_addr_s;
      wr_data_d    = gnt_data_s;
      last_grant_d = gnt_idx_s;
      for (int i = 0; i < NUM_REGS; i++) begin
        wr_dec_d[i] = (gnt_addr_s == ADDR_W'(i));
      end
    end else begin
      wr_dec_d = {NUM_REGS{1'b0}};
    end
  end

  // State registers; reset discards buffered writes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold0_q      <= BUF_EMPTY;
      hold1_q      <= BUF_EMPTY;
      addr0_q      <= {ADDR_W{1'b0}};
      addr1_q      <= {ADDR_W{1'b0}};
      data0_q      <= {DATA_W{1'b0}};
      data1_q      <= {DATA_W{1'b0}};
      last_grant_q <= 1'b1;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= {ADDR_W{1'b0}};
      wr_data_q    <= {DATA_W{1'b0}};
      wr_dec_q     <= {NUM_REGS{1'b0}};
      drop_cnt_q   <= {DROP_W{1'b0}};
    end else begin
      hold0_q      <= hold0_d;
      hold1_q      <= hold1_d;
      addr0_q      <= addr0_d;
      addr1_q      <= addr1_d;
      data0_q      <= data0_d;
      data1_q      <= data1_d;
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_dec_q     <= wr_dec_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign req0_ready = ready0_s;
  assign req1_ready = ready1_s;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign wr_dec     = wr_dec_q;
  assign pending    = {full1_s, full0_s};
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_arbiter
//   Directed scenarios followed by random traffic. A behavioural model holds
//   the two buffers as small arrays and applies the arbitration rules once per
//   clock edge; every output is compared against it after each edge.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_addr, req1_addr;
  logic [63:0] req0_data, req1_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic [31:0] wr_dec;
  logic [1:0]  pending;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;
  int obs_pulses = 0;

  // Reference model state
  bit          m_full [2];
  logic [4:0]  m_addr [2];
  logic [63:0] m_data [2];
  int          m_last;
  bit          m_wr_en;
  logic [4:0]  m_wr_addr;
  logic [63:0] m_wr_data;
  int          m_drop;

  regfile_write_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_dec     (wr_dec),
    .pending    (pending),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant();
    if (m_full[0] && m_full[1]) return 1 - m_last;
    if (m_full[0]) return 0;
    if (m_full[1]) return 1;
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_full[i] = 1'b0;
      m_addr[i] = 5'd0;
      m_data[i] = 64'd0;
    end
    m_last    = 1;
    m_wr_en   = 1'b0;
    m_wr_addr = 5'd0;
    m_wr_data = 64'd0;
    m_drop    = 0;
  endtask

  // Apply one clock edge to the model using the inputs present at that edge.
  task automatic model_edge();
    int          g;
    bit          rdy [2];
    bit          vl  [2];
    logic [4:0]  ad  [2];
    logic [63:0] dt  [2];
    g = model_grant();
    vl[0] = req0_valid; ad[0] = req0_addr; dt[0] = req0_data;
    vl[1] = req1_valid; ad[1] = req1_addr; dt[1] = req1_data;
    for (int i = 0; i < 2; i++) rdy[i] = !m_full[i] || (g == i);
    if (g >= 0) begin
      m_wr_en   = 1'b1;
      m_wr_addr = m_addr[g];
      m_wr_data = m_data[g];
      m_last    = g;
      m_full[g] = 1'b0;
    end else begin
      m_wr_en = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      if (vl[i] && rdy[i]) begin
        if (ad[i] == 5'd31) begin
          m_drop = (m_drop >= 255) ? 255 : m_drop + 1;
        end else begin
          m_full[i] = 1'b1;
          m_addr[i] = ad[i];
          m_data[i] = dt[i];
        end
      end
    end
  endtask

  task automatic check_ready();
    int g;
    g = model_grant();
    chk("req0_ready", {63'd0, req0_ready}, {63'd0, (!m_full[0] || g == 0)});
    chk("req1_ready", {63'd0, req1_ready}, {63'd0, (!m_full[1] || g == 1)});
  endtask

  task automatic check_out();
    logic [31:0] e_dec;
    e_dec = 32'd0;
    if (m_wr_en) e_dec[m_wr_addr] = 1'b1;
    chk("wr_en",    {63'd0, wr_en},    {63'd0, m_wr_en});
    chk("wr_addr",  {59'd0, wr_addr},  {59'd0, m_wr_addr});
    chk("wr_data",  wr_data,           m_wr_data);
    chk("wr_dec",   {32'd0, wr_dec},   {32'd0, e_dec});
    chk("pending",  {62'd0, pending},  {62'd0, m_full[1], m_full[0]});
    chk("drop_cnt", {56'd0, drop_cnt}, 64'(m_drop));
  endtask

  task automatic tick();
    check_ready();
    @(posedge clk);
    model_edge();
    #1;
    check_out();
    if (wr_en === 1'b1) obs_pulses++;
  endtask

  task automatic drive(input bit v0, input logic [4:0] a0, input logic [63:0] d0,
                       input bit v1, input logic [4:0] a1, input logic [63:0] d1);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
  endtask

  // Called just after an edge: pulls reset low mid-cycle and releases it
  // before the next edge.
  task automatic pulse_reset();
    idle();
    reset = 1'b0;
    #1;
    chk("rst_wr_en",    {63'd0, wr_en},    64'd0);
    chk("rst_wr_dec",   {32'd0, wr_dec},   64'd0);
    chk("rst_pending",  {62'd0, pending},  64'd0);
    chk("rst_drop_cnt", {56'd0, drop_cnt}, 64'd0);
    chk("rst_wr_addr",  {59'd0, wr_addr},  64'd0);
    chk("rst_wr_data",  wr_data,           64'd0);
    model_clear();
    #2;
    reset = 1'b1;
    #1;
  endtask

  initial begin
    int p0;
    reset = 1'b0;
    idle();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("init_wr_en",   {63'd0, wr_en},   64'd0);
    chk("init_pending", {62'd0, pending}, 64'd0);
    reset = 1'b1;

    // 1: single write to X5, strobe two edges after the handshake
    drive(1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0, 5'd0, 64'd0);
    tick();
    idle();
    chk("t1_no_early_en", {63'd0, wr_en}, 64'd0);
    tick();
    chk("t1_wr_en",   {63'd0, wr_en},   64'd1);
    chk("t1_wr_addr", {59'd0, wr_addr}, 64'd5);
    chk("t1_wr_dec",  {32'd0, wr_dec},  64'h20);
    chk("t1_wr_data", wr_data,          64'hDEAD_BEEF);
    tick();
    chk("t1_one_pulse", {63'd0, wr_en}, 64'd0);

    // 2: simultaneous X1/X2 after reset, req0 refills while X1 drains
    pulse_reset();
    drive(1'b1, 5'd1, 64'h11, 1'b1, 5'd2, 64'h22);
    tick();
    drive(1'b1, 5'd12, 64'hC, 1'b0, 5'd0, 64'd0);
    tick();
    chk("t2_first_x1", {59'd0, wr_addr}, 64'd1);
    idle();
    tick();
    chk("t2_second_x2", {59'd0, wr_addr}, 64'd2);
    tick();
    chk("t2_then_x12", {59'd0, wr_addr}, 64'd12);
    repeat (2) tick();

    // 3: req0 streams X3..X10 back to back
    p0 = obs_pulses;
    for (int i = 3; i <= 10; i++) begin
      drive(1'b1, 5'(i), 64'(i * 16), 1'b0, 5'd0, 64'd0);
      chk("t3_ready0", {63'd0, req0_ready}, 64'd1);
      tick();
    end
    idle();
    repeat (3) tick();
    chk("t3_pulses", 64'(obs_pulses - p0), 64'd8);

    // 4: 300 writes to the zero register through req1
    p0 = obs_pulses;
    for (int i = 0; i < 300; i++) begin
      drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd31, 64'h55);
      tick();
    end
    idle();
    tick();
    chk("t4_no_wr_en", 64'(obs_pulses - p0), 64'd0);
    chk("t4_drop_sat", {56'd0, drop_cnt}, 64'hFF);

    // 5: both buffers full, reset mid-cycle
    drive(1'b1, 5'd4, 64'h4, 1'b1, 5'd6, 64'h6);
    tick();
    chk("t5_both_full", {62'd0, pending}, 64'd3);
    pulse_reset();
    p0 = obs_pulses;
    repeat (4) tick();
    chk("t5_no_wr_after", 64'(obs_pulses - p0), 64'd0);

    // 6: both requesters target X7, contended
    drive(1'b1, 5'd7, 64'hA, 1'b1, 5'd7, 64'hB);
    tick();
    idle();
    tick();
    chk("t6_first_a", wr_data, 64'hA);
    tick();
    chk("t6_last_b", wr_data, 64'hB);
    chk("t6_addr7", {59'd0, wr_addr}, 64'd7);
    tick();

    // Random traffic with one mid-run reset
    for (int c = 0; c < 500; c++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom(), $urandom()},
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom(), $urandom()});
      tick();
      if (c == 250) pulse_reset();
    end
    idle();
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
